uart_tx_path: RTL and testbench

UART_TX_PATH -- requirements
Module: uart_tx_path

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_tx_path.sv | 133 +++++++++++++
 tb/tb_uart_tx_path.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants: default line parameters and FSM encodings for the
// transmit and receive paths.
package uart_pkg;

    localparam int DBIT_DEFAULT    = 8;
    localparam int SB_TICK_DEFAULT = 16;
    localparam int DVSR_DEFAULT    = 163;
    localparam int OVERSAMPLE      = 16;

    typedef enum logic [1:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_STOP
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_STOP
    } rx_state_t;

endpackage

// File: rtl/uart_fifo.sv
// Small synchronous FIFO with registered full/empty flags, shared by the
// UART transmit and receive paths.
module uart_fifo #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] w_data,
    output logic [WIDTH-1:0] r_data,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]  mem [2**ADDR_W];
    logic [ADDR_W-1:0] w_ptr;
    logic [ADDR_W-1:0] r_ptr;
    logic [ADDR_W-1:0] w_ptr_nxt;
    logic [ADDR_W-1:0] r_ptr_nxt;
    logic              wr_en;
    logic              rd_en;

    // A write against a full FIFO is dropped even if a pop lands on the same edge.
    assign wr_en     = wr && !full;
    assign rd_en     = rd && !empty;
    assign w_ptr_nxt = w_ptr + 1'b1;
    assign r_ptr_nxt = r_ptr + 1'b1;
    assign r_data    = mem[r_ptr];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[w_ptr] <= w_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            w_ptr <= '0;
            r_ptr <= '0;
            full  <= 1'b0;
            empty <= 1'b1;
        end else begin
            case ({wr_en, rd_en})
                2'b10: begin
                    w_ptr <= w_ptr_nxt;
                    empty <= 1'b0;
                    full  <= (w_ptr_nxt == r_ptr);
                end
                2'b01: begin
                    r_ptr <= r_ptr_nxt;
                    full  <= 1'b0;
                    empty <= (r_ptr_nxt == w_ptr);
                end
                2'b11: begin
                    w_ptr <= w_ptr_nxt;
                    r_ptr <= r_ptr_nxt;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_path.sv
// UART transmit path: free-running baud tick, byte FIFO and a serialiser FSM
// driving a registered, idle-high tx line.
module uart_tx_path
    import uart_pkg::*;
#(
    parameter int DBIT    = DBIT_DEFAULT,
    parameter int SB_TICK = SB_TICK_DEFAULT,
    parameter int DVSR    = DVSR_DEFAULT,
    parameter int FIFO_W  = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            wr_uart,
    input  logic [DBIT-1:0] w_data,
    output logic            tx,
    output logic            tx_full,
    output logic            tx_empty,
    output logic            tx_busy,
    output logic            tx_done_tick
);

    localparam int CNT_W = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int S_MAX = (SB_TICK > OVERSAMPLE) ? SB_TICK : OVERSAMPLE;
    localparam int S_W   = $clog2(S_MAX);
    localparam int N_W   = (DBIT > 1) ? $clog2(DBIT) : 1;

    logic [CNT_W-1:0] baud_cnt;
    logic             tick;
    tx_state_t        state;
    logic [S_W-1:0]   s;
    logic [N_W-1:0]   n;
    logic [DBIT-1:0]  b;
    logic [DBIT-1:0]  fifo_data;
    logic             pop;

    assign tick = (baud_cnt == CNT_W'(DVSR - 1));
    assign pop  = (state == TX_IDLE) && !tx_empty;

    // Tick phase is never realigned to a frame, so the first start bit may run short.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt <= '0;
        end else if (tick) begin
            baud_cnt <= '0;
        end else begin
            baud_cnt <= baud_cnt + 1'b1;
        end
    end

    uart_fifo #(
        .WIDTH  (DBIT),
        .ADDR_W (FIFO_W)
    ) u_fifo (
        .clk    (clk),
        .reset  (reset),
        .wr     (wr_uart),
        .rd     (pop),
        .w_data (w_data),
        .r_data (fifo_data),
        .full   (tx_full),
        .empty  (tx_empty)
    );

    // tx, tx_busy and tx_done_tick are updated on the same edge as the state change they reflect.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= TX_IDLE;
            s            <= '0;
            n            <= '0;
            b            <= '0;
            tx           <= 1'b1;
            tx_busy      <= 1'b0;
            tx_done_tick <= 1'b0;
        end else begin
            tx_done_tick <= 1'b0;
            case (state)
                TX_IDLE: begin
                    if (!tx_empty) begin
                        b       <= fifo_data;
                        s       <= '0;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= TX_START;
                    end
                end
                TX_START: begin
                    if (tick) begin
                        if (s == S_W'(OVERSAMPLE - 1)) begin
                            s     <= '0;
                            n     <= '0;
                            tx    <= b[0];
                            state <= TX_DATA;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                TX_DATA: begin
                    if (tick) begin
                        if (s == S_W'(OVERSAMPLE - 1)) begin
                            s <= '0;
                            b <= b >> 1;
                            if (n == N_W'(DBIT - 1)) begin
                                tx    <= 1'b1;
                                state <= TX_STOP;
                            end else begin
                                n  <= n + 1'b1;
                                tx <= b[1];
                            end
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                TX_STOP: begin
                    if (tick) begin
                        if (s == S_W'(SB_TICK - 1)) begin
                            tx_done_tick <= 1'b1;
                            tx_busy      <= 1'b0;
                            state        <= TX_IDLE;
                        end else begin
                            s <= s + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= TX_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_path.sv
// Self-checking bench for uart_tx_path: a line-level UART receiver model
// decodes tx and the results are compared against the bytes the bench wrote.
module tb_uart_tx_path;

    localparam int BIT_CLKS = 32;

    logic       clk;
    logic       reset;
    logic       wr_uart;
    logic [7:0] w_data;
    logic       tx;
    logic       tx_full;
    logic       tx_empty;
    logic       tx_busy;
    logic       tx_done_tick;

    logic       wr2;
    logic [7:0] w_data2;
    logic       tx2;
    logic       full2;
    logic       empty2;
    logic       busy2;
    logic       done2;

    int vectors     = 0;
    int miscompares = 0;

    int         cyc       = 0;
    logic       tx_q      = 1'b1;
    logic       tx2_q     = 1'b1;
    bit         in_frame  = 1'b0;
    int         frame_t0  = 0;
    int         rel       = 0;
    int         frame_err = 0;
    logic [7:0] rx_shift  = 8'h00;
    int         trans_q[$];
    int         done_q[$];
    int         t0_q[$];
    logic [7:0] rx_q[$];
    int         falls2_q[$];
    int         rises2_q[$];
    int         done2_q[$];

    uart_tx_path #(
        .DBIT    (8),
        .SB_TICK (16),
        .DVSR    (2),
        .FIFO_W  (2)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_uart      (wr_uart),
        .w_data       (w_data),
        .tx           (tx),
        .tx_full      (tx_full),
        .tx_empty     (tx_empty),
        .tx_busy      (tx_busy),
        .tx_done_tick (tx_done_tick)
    );

    uart_tx_path #(
        .DBIT    (8),
        .SB_TICK (32),
        .DVSR    (2),
        .FIFO_W  (2)
    ) dut_sb32 (
        .clk          (clk),
        .reset        (reset),
        .wr_uart      (wr2),
        .w_data       (w_data2),
        .tx           (tx2),
        .tx_full      (full2),
        .tx_empty     (empty2),
        .tx_busy      (busy2),
        .tx_done_tick (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line monitor: counts edges, logs tx transitions and done pulses, and
    // decodes frames by sampling each bit at its centre after a start edge.
    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!reset) begin
            in_frame = 1'b0;
        end else begin
            if (tx !== tx_q) trans_q.push_back(cyc - 1);
            if (tx_done_tick === 1'b1) done_q.push_back(cyc - 1);
            if (in_frame) begin
                rel = cyc - 1 - frame_t0;
                if (rel % BIT_CLKS == BIT_CLKS / 2) begin
                    if (rel / BIT_CLKS >= 1 && rel / BIT_CLKS <= 8) begin
                        rx_shift[rel / BIT_CLKS - 1] = tx;
                    end else if (rel / BIT_CLKS == 9) begin
                        if (tx !== 1'b1) frame_err++;
                        rx_q.push_back(rx_shift);
                        in_frame = 1'b0;
                    end
                end
            end else if (tx_q === 1'b1 && tx === 1'b0) begin
                in_frame = 1'b1;
                frame_t0 = cyc - 1;
                t0_q.push_back(cyc - 1);
            end
            if (tx2_q === 1'b1 && tx2 === 1'b0) falls2_q.push_back(cyc - 1);
            if (tx2_q === 1'b0 && tx2 === 1'b1) rises2_q.push_back(cyc - 1);
            if (done2 === 1'b1) done2_q.push_back(cyc - 1);
        end
        tx_q  = tx;
        tx2_q = tx2;
    end

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [7:0] data);
        @(negedge clk);
        wr_uart = 1'b1;
        w_data  = data;
    endtask

    task automatic release_write();
        @(negedge clk);
        wr_uart = 1'b0;
    endtask

    task automatic wait_frames(input int count, input int budget, input string tag);
        int waited = 0;
        while (rx_q.size() < count && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check_output(tag, 32'(rx_q.size() >= count), 32'd1);
    endtask

    task automatic wait_done(input int count, input int budget, input string tag);
        int waited = 0;
        while (done_q.size() < count && waited < budget) begin
            @(negedge clk);
            waited++;
        end
        check_output(tag, 32'(done_q.size() >= count), 32'd1);
    endtask

    function automatic int q_at(input int q[$], input int i);
        if (i >= 0 && i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic logic [31:0] rx_at(input int i);
        if (i >= 0 && i < rx_q.size()) return {24'h0, rx_q[i]};
        return 32'hFFFF_FFFF;
    endfunction

    task automatic clear_logs();
        trans_q.delete();
        done_q.delete();
        t0_q.delete();
        rx_q.delete();
    endtask

    initial begin
        logic [7:0] vals[6];
        logic [7:0] sent[$];
        int         w_edge;
        int         n_wr;
        int         exp_n;
        int         waited;
        bit         found;
        logic [7:0] v;

        reset   = 1'b1;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        wr2     = 1'b0;
        w_data2 = 8'h00;
        #2;
        reset = 1'b0;
        #1;
        check_output("rst_tx", tx, 1);
        check_output("rst_busy", tx_busy, 0);
        check_output("rst_done", tx_done_tick, 0);
        check_output("rst_full", tx_full, 0);
        check_output("rst_empty", tx_empty, 1);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Single 0x55 frame: bit values, bit lengths, latency and done pulse.
        clear_logs();
        apply_stimulus(8'h55);
        w_edge = cyc + 1;
        release_write();
        wait_frames(1, 600, "t1_frame_timeout");
        check_output("t1_busy_mid", tx_busy, 1);
        wait_done(1, 100, "t1_done_timeout");
        repeat (4) @(negedge clk);
        check_output("t1_byte", rx_at(0), 32'h55);
        check_output("t1_trans_cnt", trans_q.size(), 10);
        check_output("t1_latency", q_at(trans_q, 0), w_edge + 1);
        check_output("t1_start_len", 32'((q_at(trans_q, 1) - q_at(trans_q, 0)) inside {31, 32}), 1);
        for (int i = 1; i < 9; i++) begin
            check_output($sformatf("t1_bit%0d_len", i - 1), q_at(trans_q, i + 1) - q_at(trans_q, i), BIT_CLKS);
        end
        check_output("t1_stop_len", q_at(done_q, 0) - q_at(trans_q, 9), BIT_CLKS);
        check_output("t1_done_cnt", done_q.size(), 1);
        check_output("t1_busy_end", tx_busy, 0);
        check_output("t1_empty_end", tx_empty, 1);
        check_output("t1_tx_idle", tx, 1);

        // Back-to-back 0xA3, 0x0F.
        clear_logs();
        apply_stimulus(8'hA3);
        apply_stimulus(8'h0F);
        release_write();
        wait_frames(2, 1200, "t2_frame_timeout");
        wait_done(2, 100, "t2_done_timeout");
        repeat (4) @(negedge clk);
        check_output("t2_byte0", rx_at(0), 32'hA3);
        check_output("t2_byte1", rx_at(1), 32'h0F);
        check_output("t2_gapless", q_at(t0_q, 1), q_at(done_q, 0) + 1);
        check_output("t2_stop_ok", frame_err, 0);

        // Six writes while idle, then a write on the same edge as a full-FIFO pop.
        clear_logs();
        vals = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 4) check_output("t3_not_full_4", tx_full, 0);
            if (i == 5) check_output("t3_full_5", tx_full, 1);
            wr_uart = 1'b1;
            w_data  = vals[i];
        end
        release_write();
        check_output("t3_full_drop", tx_full, 1);
        found  = 1'b0;
        waited = 0;
        while (!found && waited < 1000) begin
            @(negedge clk);
            waited++;
            if (tx_done_tick === 1'b1) found = 1'b1;
        end
        check_output("t3_done_seen", 32'(found), 1);
        wr_uart = 1'b1;
        w_data  = 8'hEE;
        release_write();
        check_output("t3_full_after_pop", tx_full, 0);
        check_output("t3_empty_after_pop", tx_empty, 0);
        wait_frames(5, 2500, "t3_frame_timeout");
        wait_done(5, 100, "t3_done_timeout");
        repeat (40) @(negedge clk);
        check_output("t3_frame_cnt", rx_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("t3_byte%0d", i), rx_at(i), {24'h0, vals[i]});
        end
        check_output("t3_empty_end", tx_empty, 1);

        // Random bursts while idle: anything past five consecutive writes is dropped.
        for (int it = 0; it < 4; it++) begin
            clear_logs();
            sent.delete();
            n_wr = int'($urandom_range(1, 7));
            for (int i = 0; i < n_wr; i++) begin
                v = 8'($urandom);
                sent.push_back(v);
                apply_stimulus(v);
            end
            release_write();
            check_output($sformatf("t4_%0d_full", it), tx_full, 32'(n_wr >= 5));
            exp_n = (n_wr > 5) ? 5 : n_wr;
            wait_frames(exp_n, 400 * exp_n + 200, $sformatf("t4_%0d_frame_timeout", it));
            wait_done(exp_n, 100, $sformatf("t4_%0d_done_timeout", it));
            repeat (40) @(negedge clk);
            check_output($sformatf("t4_%0d_frame_cnt", it), rx_q.size(), exp_n);
            for (int i = 0; i < exp_n; i++) begin
                check_output($sformatf("t4_%0d_byte%0d", it, i), rx_at(i), {24'h0, sent[i]});
            end
            check_output($sformatf("t4_%0d_busy", it), tx_busy, 0);
            check_output($sformatf("t4_%0d_empty", it), tx_empty, 1);
        end

        // Reset in the middle of the data bits, with a second byte queued.
        clear_logs();
        apply_stimulus(8'h00);
        apply_stimulus(8'h5A);
        release_write();
        repeat (100) @(negedge clk);
        check_output("t5_pre_tx", tx, 0);
        check_output("t5_pre_busy", tx_busy, 1);
        check_output("t5_pre_empty", tx_empty, 0);
        #2;
        reset = 1'b0;
        #1;
        check_output("t5_rst_tx", tx, 1);
        check_output("t5_rst_busy", tx_busy, 0);
        check_output("t5_rst_empty", tx_empty, 1);
        check_output("t5_rst_full", tx_full, 0);
        check_output("t5_rst_done", tx_done_tick, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        clear_logs();
        repeat (300) @(negedge clk);
        check_output("t5_idle_trans", trans_q.size(), 0);
        check_output("t5_no_done", done_q.size(), 0);
        check_output("t5_no_frame", rx_q.size(), 0);
        check_output("t5_idle_busy", tx_busy, 0);
        apply_stimulus(8'hC3);
        release_write();
        wait_frames(1, 600, "t5_frame_timeout");
        check_output("t5_recover_byte", rx_at(0), 32'hC3);
        wait_done(1, 100, "t5_done_timeout");

        // 32-tick stop bit on the second instance.
        falls2_q.delete();
        rises2_q.delete();
        done2_q.delete();
        @(negedge clk);
        wr2     = 1'b1;
        w_data2 = 8'hFF;
        @(negedge clk);
        wr2 = 1'b0;
        waited = 0;
        while (done2_q.size() < 1 && waited < 800) begin
            @(negedge clk);
            waited++;
        end
        check_output("t6_done_seen", 32'(done2_q.size() >= 1), 1);
        repeat (10) @(negedge clk);
        check_output("t6_falls", falls2_q.size(), 1);
        check_output("t6_rises", rises2_q.size(), 1);
        check_output("t6_data_stop_len", q_at(done2_q, 0) - q_at(rises2_q, 0), 8 * BIT_CLKS + 2 * BIT_CLKS);
        check_output("t6_frame_len", 32'((q_at(done2_q, 0) - q_at(falls2_q, 0)) inside {351, 352}), 1);
        check_output("t6_done_cnt", done2_q.size(), 1);
        check_output("t6_tx_idle", tx2, 1);
        check_output("t6_busy", busy2, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
